// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch (F) and the data path (D).
// One access in flight at a time, D-priority with a starvation guard for F, and a sticky timeout error.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    f_req,
    input  logic [ADDR_WIDTH-1:0]   f_addr,
    output logic                    f_gnt,
    output logic                    f_rvalid,
    output logic [DATA_WIDTH-1:0]   f_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic                    bus_error
);

    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int WAIT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST  = WAIT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [7:0]            STARVE_MAX = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t                  state_r;
    logic                    owner_d_r;
    logic [7:0]              starve_cnt_r;
    logic [WAIT_WIDTH-1:0]   wait_cnt_r;
    logic                    mem_we_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [DATA_WIDTH-1:0]   mem_wdata_r;
    logic [BE_WIDTH-1:0]     mem_be_r;
    logic                    f_rvalid_r;
    logic                    d_rvalid_r;
    logic [DATA_WIDTH-1:0]   f_rdata_r;
    logic [DATA_WIDTH-1:0]   d_rdata_r;
    logic                    bus_error_r;
    logic                    f_gnt_s;
    logic                    d_gnt_s;
    logic                    contested_s;

    // Grant decision: D wins unless F is contesting and has been passed over STARVE_LIMIT times.
    always_comb begin
        f_gnt_s     = 1'b0;
        d_gnt_s     = 1'b0;
        contested_s = f_req & d_req;
        if (state_r == ST_IDLE) begin
            if (d_req && !(contested_s && (starve_cnt_r == STARVE_MAX))) begin
                d_gnt_s = 1'b1;
            end else if (f_req) begin
                f_gnt_s = 1'b1;
            end else begin
                f_gnt_s = 1'b0;
                d_gnt_s = 1'b0;
            end
        end else begin
            f_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Access sequencing: latch payload on grant, complete on ack, trap into ERROR on timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_d_r    <= 1'b0;
            starve_cnt_r <= 8'd0;
            wait_cnt_r   <= '0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_be_r     <= '0;
            f_rvalid_r   <= 1'b0;
            d_rvalid_r   <= 1'b0;
            f_rdata_r    <= '0;
            d_rdata_r    <= '0;
            bus_error_r  <= 1'b0;
        end else begin
            f_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (d_gnt_s) begin
                        state_r     <= ST_BUSY;
                        owner_d_r   <= 1'b1;
                        wait_cnt_r  <= '0;
                        mem_we_r    <= d_we;
                        mem_addr_r  <= d_addr;
                        mem_wdata_r <= d_wdata;
                        mem_be_r    <= d_be;
                        if (contested_s && (starve_cnt_r < STARVE_MAX)) begin
                            starve_cnt_r <= starve_cnt_r + 8'd1;
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else if (f_gnt_s) begin
                        state_r      <= ST_BUSY;
                        owner_d_r    <= 1'b0;
                        wait_cnt_r   <= '0;
                        mem_we_r     <= 1'b0;
                        mem_addr_r   <= f_addr;
                        mem_wdata_r  <= '0;
                        mem_be_r     <= '1;
                        starve_cnt_r <= 8'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // A late ack on the limit cycle still completes normally.
                    if (mem_ack) begin
                        state_r <= ST_IDLE;
                        if (owner_d_r) begin
                            d_rdata_r  <= mem_rdata;
                            d_rvalid_r <= 1'b1;
                        end else begin
                            f_rdata_r  <= mem_rdata;
                            f_rvalid_r <= 1'b1;
                        end
                    end else if ((TIMEOUT != 0) && (wait_cnt_r == WAIT_LAST)) begin
                        state_r     <= ST_ERROR;
                        bus_error_r <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt_r <= wait_cnt_r + WAIT_WIDTH'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                ST_ERROR: begin
                    state_r     <= ST_ERROR;
                    bus_error_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_ERROR;
                    bus_error_r <= 1'b1;
                end
            endcase
        end
    end

    assign f_gnt     = f_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign f_rvalid  = f_rvalid_r;
    assign d_rvalid  = d_rvalid_r;
    assign f_rdata   = f_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign mem_req   = (state_r == ST_BUSY);
    assign busy      = (state_r == ST_BUSY);
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign bus_error = bus_error_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, starvation order, delayed store,
// ack on the timeout cycle, async reset mid-access, and the sticky timeout error.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'h0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_be = 4'hF;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy, bus_error;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_f;

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clock); #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bus_error", 64'(bus_error), 64'd0);
        chk("rst_rvalids", 64'({f_rvalid, d_rvalid}), 64'd0);
        chk("rst_rdata", 64'({f_rdata, d_rdata}), 64'd0);
        chk("rst_mem_bus", 64'({mem_we, mem_be, mem_addr}), 64'd0);
        @(negedge clock); reset = 1'b0;

        // Single fetch, immediate ack
        @(negedge clock); f_req = 1'b1; f_addr = 32'h100; #1;
        chk("t1_f_gnt", 64'({f_gnt, d_gnt}), 64'b10);
        @(negedge clock); f_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        chk("t1_mem_req", 64'({mem_req, busy, mem_we}), 64'b110);
        chk("t1_mem_addr", 64'(mem_addr), 64'h100);
        chk("t1_mem_be", 64'(mem_be), 64'hF);
        chk("t1_no_rvalid_yet", 64'(f_rvalid), 64'd0);
        @(negedge clock); mem_ack = 1'b0; #1;
        chk("t1_f_rvalid", 64'({f_rvalid, d_rvalid}), 64'b10);
        chk("t1_f_rdata", 64'(f_rdata), 64'hDEADBEEF);
        chk("t1_idle", 64'({mem_req, busy}), 64'd0);
        @(negedge clock); #1;
        chk("t1_rvalid_pulse", 64'(f_rvalid), 64'd0);
        chk("t1_f_rdata_hold", 64'(f_rdata), 64'hDEADBEEF);

        // Both requesters held continuously: D,D,D,D,F,D,D,D,D,F
        exp_f = 10'b1000010000;
        f_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0; d_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); mem_ack = 1'b0; f_req = 1'b1; d_req = 1'b1; #1;
            chk($sformatf("t2_f_gnt_%0d", i), 64'(f_gnt), 64'(exp_f[i]));
            chk($sformatf("t2_d_gnt_%0d", i), 64'(d_gnt), 64'(!exp_f[i]));
            if (i > 0) begin
                chk($sformatf("t2_rvalid_%0d", i), 64'({f_rvalid, d_rvalid}),
                    exp_f[i-1] ? 64'b10 : 64'b01);
            end
            @(negedge clock); mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(i); #1;
            chk($sformatf("t2_busy_nognt_%0d", i), 64'({busy, f_gnt, d_gnt}), 64'b100);
            chk($sformatf("t2_addr_%0d", i), 64'(mem_addr), exp_f[i] ? 64'h200 : 64'h300);
        end
        @(negedge clock); mem_ack = 1'b0; f_req = 1'b0; d_req = 1'b0; #1;
        chk("t2_last_rvalid", 64'({f_rvalid, d_rvalid}), 64'b10);
        chk("t2_f_rdata", 64'(f_rdata), 64'hA9);
        chk("t2_d_rdata", 64'(d_rdata), 64'hA8);

        // Store with ack delayed to the 5th BUSY cycle; F waits
        @(negedge clock);
        f_req = 1'b1; f_addr = 32'h500;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'b0011; #1;
        chk("t3_d_gnt", 64'({f_gnt, d_gnt}), 64'b01);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock); d_req = 1'b0; d_we = 1'b0; mem_ack = (k == 5); mem_rdata = 32'h55AA55AA; #1;
            chk($sformatf("t3_wr_%0d", k), 64'({mem_req, mem_we, mem_be}), 64'b11_0011);
            chk($sformatf("t3_addr_%0d", k), 64'(mem_addr), 64'h40);
            chk($sformatf("t3_wdata_%0d", k), 64'(mem_wdata), 64'h12345678);
            chk($sformatf("t3_no_f_gnt_%0d", k), 64'({f_gnt, d_rvalid}), 64'd0);
        end
        @(negedge clock); mem_ack = 1'b0; #1;
        chk("t3_d_rvalid", 64'({f_rvalid, d_rvalid}), 64'b01);
        chk("t3_d_rdata", 64'(d_rdata), 64'h55AA55AA);
        chk("t3_f_gnt_after", 64'(f_gnt), 64'd1);
        @(negedge clock); f_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
        chk("t3_d_rvalid_once", 64'(d_rvalid), 64'd0);
        chk("t3_f_access", 64'({mem_we, mem_be, mem_addr}), {27'd0, 1'b0, 4'hF, 32'h500});
        @(negedge clock); mem_ack = 1'b0; #1;
        chk("t3_f_rvalid", 64'({f_rvalid, d_rvalid}), 64'b10);
        chk("t3_f_rdata", 64'(f_rdata), 64'hCAFEF00D);
        chk("t3_d_rdata_hold", 64'(d_rdata), 64'h55AA55AA);

        // Ack arrives on the 8th BUSY cycle: normal completion
        @(negedge clock); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF; #1;
        chk("t6_d_gnt", 64'(d_gnt), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock); d_req = 1'b0; mem_ack = (k == 8); mem_rdata = 32'h13579BDF; #1;
            chk($sformatf("t6_busy_%0d", k), 64'({busy, bus_error}), 64'b10);
        end
        @(negedge clock); mem_ack = 1'b0; #1;
        chk("t6_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("t6_d_rdata", 64'(d_rdata), 64'h13579BDF);
        chk("t6_no_error", 64'({bus_error, busy}), 64'd0);

        // Saturate starvation counter, then reset mid-BUSY
        f_addr = 32'h200; d_addr = 32'h300;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock); mem_ack = 1'b0; f_req = 1'b1; d_req = 1'b1; #1;
            chk($sformatf("t5_pre_d_gnt_%0d", j), 64'({f_gnt, d_gnt}), 64'b01);
            @(negedge clock); mem_ack = 1'b1;
        end
        @(negedge clock); mem_ack = 1'b0; f_req = 1'b0; d_req = 1'b1; #1;
        chk("t5_uncontested_d", 64'(d_gnt), 64'd1);
        @(negedge clock); d_req = 1'b0; #1;
        chk("t5_busy_c1", 64'(busy), 64'd1);
        @(negedge clock);
        @(negedge clock); #2; reset = 1'b1; #1;
        chk("t5_async_drop", 64'({mem_req, busy, f_rvalid, d_rvalid}), 64'd0);
        chk("t5_rdata_cleared", 64'(d_rdata), 64'd0);
        @(negedge clock); reset = 1'b0; f_req = 1'b1; d_req = 1'b1; #1;
        chk("t5_starve_cleared", 64'({f_gnt, d_gnt}), 64'b01);
        @(negedge clock); d_req = 1'b0; mem_ack = 1'b1; #1;
        @(negedge clock); mem_ack = 1'b0; #1;
        chk("t5_d_done_f_gnt", 64'({d_rvalid, f_gnt}), 64'b11);
        @(negedge clock); f_req = 1'b0; mem_ack = 1'b1;
        @(negedge clock); mem_ack = 1'b0; #1;
        chk("t5_f_rvalid", 64'(f_rvalid), 64'd1);

        // Timeout: no ack ever
        @(negedge clock); d_req = 1'b1; d_addr = 32'h90; #1;
        chk("t4_d_gnt", 64'(d_gnt), 64'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock); d_req = 1'b0; #1;
            chk($sformatf("t4_wait_%0d", k), 64'({mem_req, bus_error}), 64'b10);
        end
        @(negedge clock); f_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1; #1;
        chk("t4_bus_error", 64'(bus_error), 64'd1);
        chk("t4_halted", 64'({mem_req, busy, d_rvalid, f_gnt, d_gnt}), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            chk($sformatf("t4_sticky_%0d", k), 64'({bus_error, f_gnt, d_gnt, f_rvalid, d_rvalid}), 64'b10000);
        end
        @(negedge clock); reset = 1'b1; mem_ack = 1'b0; f_req = 1'b0; d_req = 1'b0; #1;
        chk("t4_reset_clears", 64'(bus_error), 64'd0);
        @(negedge clock); reset = 1'b0; f_req = 1'b1; #1;
        chk("t4_gnt_after_reset", 64'(f_gnt), 64'd1);
        @(negedge clock); f_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
